// File: rtl/stream_fifo_pkg.sv
// Shared constants, pointer-width helper and default pointer type for stream_fifo.
package stream_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_AF_THRESH  = 12;

    // One extra MSB beyond the index bits separates full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEF_PTR_W = ptr_width(DEF_DEPTH);

    typedef logic [DEF_PTR_W-1:0] fifo_ptr_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// Register-array storage for stream_fifo: one clocked write port, one asynchronous read port.
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]      o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word fall-through valid/ready FIFO with registered count and flags.
// Optional almost_full output enabled by defining STREAM_FIFO_ALMOST_FULL_EN.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH      = DEF_DEPTH,
    parameter int unsigned FIFO_AF_THRESH  = DEF_AF_THRESH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    input  logic [FIFO_DATA_WIDTH-1:0]    s_data,
    output logic                          s_ready,
    output logic                          m_valid,
    output logic [FIFO_DATA_WIDTH-1:0]    m_data,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef STREAM_FIFO_ALMOST_FULL_EN
    ,
    output logic                          almost_full
`endif
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned AW    = PTR_W - 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (FIFO_AF_THRESH < 1 || FIFO_AF_THRESH > FIFO_DEPTH) begin : g_bad_thresh
        $error("stream_fifo: FIFO_AF_THRESH must be in 1..FIFO_DEPTH");
    end

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_count;
    logic             r_s_ready;
    logic             r_m_valid;

    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_count_nxt;
    logic             w_full_nxt;
    logic             w_empty_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push = s_valid && r_s_ready;
    assign w_pop  = r_m_valid && m_ready;

    // Next pointers/count; flags are derived from next pointers so they can be registered.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        w_count_nxt  = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + PTR_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - PTR_W'(1);
        end
        w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt  = (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                      (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_count   <= w_count_nxt;
            r_s_ready <= !w_full_nxt;
            r_m_valid <= !w_empty_nxt;
        end
    end

    stream_fifo_mem #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (s_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (m_data)
    );

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign count   = r_count;

`ifdef STREAM_FIFO_ALMOST_FULL_EN
    logic r_almost_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= PTR_W'(FIFO_AF_THRESH));
        end
    end

    assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: driver queues accepted beats, monitor checks pops and flags.
module tb_stream_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [CW-1:0] count;
`ifdef STREAM_FIFO_ALMOST_FULL_EN
    logic          almost_full;
`endif

    stream_fifo #(
        .FIFO_DATA_WIDTH (DW),
        .FIFO_DEPTH      (DEPTH),
        .FIFO_AF_THRESH  (AF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .count   (count)
`ifdef STREAM_FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            occ   = 0;
    int            n_pop = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_word;
    logic [DW-1:0] last_out;
    bit            mon_push;
    bit            mon_pop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy model checks flags every cycle and pops expected data on handshake.
    always @(negedge clk) begin
        #4;
        if (reset) begin
            occ = 0;
            exp_q.delete();
        end else begin
            chk("count", 64'(count), 64'(occ));
            chk("s_ready", 64'(s_ready), 64'(occ < int'(DEPTH)));
            chk("m_valid", 64'(m_valid), 64'(occ > 0));
`ifdef STREAM_FIFO_ALMOST_FULL_EN
            chk("almost_full", 64'(almost_full), 64'(occ >= int'(AF)));
`endif
            mon_push = s_valid && (occ < int'(DEPTH));
            mon_pop  = m_ready && (occ > 0);
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_underflow: got 0x%0h expected no beat", m_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("m_data", 64'(m_data), 64'(exp_word));
                end
                last_out = m_data;
                n_pop++;
            end
            occ = occ + int'(mon_push) - int'(mon_pop);
        end
    end

    // Driver step: record an accepted beat as expected output, then advance one cycle.
    task automatic step(output bit acc);
        acc = !reset && s_valid && s_ready;
        if (acc) exp_q.push_back(s_data);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        bit pend;
        int idx;
        int cyc;
        int pop0;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset then idle
        repeat (10) step(acc);
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_s_ready", 64'(s_ready), 64'd1);
        chk("idle_m_valid", 64'(m_valid), 64'd0);

        // Fill without draining
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            step(acc);
            chk("fill_accept", 64'(acc), 64'd1);
        end
        s_data = 32'hDEADBEEF;
        repeat (3) begin
            step(acc);
            chk("full_holdoff", 64'(acc), 64'd0);
        end
        s_valid = 1'b0;
        chk("full_count", 64'(count), 64'd16);
        chk("full_s_ready", 64'(s_ready), 64'd0);
`ifdef STREAM_FIFO_ALMOST_FULL_EN
        chk("full_almost_full", 64'(almost_full), 64'd1);
`endif

        // Drain a full FIFO
        pop0    = n_pop;
        m_ready = 1'b1;
        repeat (16) step(acc);
        chk("drain_pops", 64'(n_pop - pop0), 64'd16);
        chk("drain_m_valid", 64'(m_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);

        // Streaming at full rate
        pop0    = n_pop;
        s_valid = 1'b1;
        idx     = 0;
        cyc     = 0;
        while (idx < 64 && cyc < 200) begin
            s_data = 32'h1000_0000 + DW'(idx);
            step(acc);
            if (acc) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        step(acc);
        chk("stream_cycles", 64'(cyc), 64'd64);
        chk("stream_pops", 64'(n_pop - pop0), 64'd64);

        // Random throttled traffic with wrap-around
        idx  = 0;
        cyc  = 0;
        pend = 1'b0;
        while (idx < 1000 && cyc < 20000) begin
            if (!pend) begin
                s_valid = ($urandom_range(0, 1) == 0);
                if (s_valid) s_data = $urandom;
            end
            m_ready = ($urandom_range(0, 2) == 0);
            step(acc);
            pend = s_valid && !acc;
            if (acc) idx++;
            cyc++;
        end
        chk("rand_accepted", 64'(idx), 64'd1000);
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc     = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step(acc);
            cyc++;
        end
        step(acc);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_count", 64'(count), 64'd0);

        // Reset mid-burst with 7 entries held
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            step(acc);
        end
        s_valid = 1'b0;
        chk("pre_reset_count", 64'(count), 64'd7);
        reset = 1'b1;
        step(acc);
        reset = 1'b0;
        chk("post_reset_count", 64'(count), 64'd0);
        chk("post_reset_m_valid", 64'(m_valid), 64'd0);
        pop0    = n_pop;
        s_valid = 1'b1;
        s_data  = 32'hA5A5A5A5;
        step(acc);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step(acc);
        step(acc);
        chk("post_reset_pops", 64'(n_pop - pop0), 64'd1);
        chk("post_reset_first", 64'(last_out), 64'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous valid/ready FIFO sitting directly downstream of `skid_buffer`: consumes its `m_valid/m_data/m_ready` stream and absorbs burst-rate mismatch towards the next consumer. First-word fall-through. Both sides obey the same AXI-stream style handshake as `skid_buffer`. Single clock domain, no width conversion.

## Interface
- `FIFO_DATA_WIDTH`, 32, payload width in bits.
- `FIFO_DEPTH`, 16, entry count; power of two, ≥2.
- `FIFO_AF_THRESH`, 12, almost-full level, 1..`FIFO_DEPTH` (used only with the macro).
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream beat valid.
- `s_data`  in  `FIFO_DATA_WIDTH`  upstream payload.
- `s_ready`  out  1  FIFO can accept a beat.
- `m_valid`  out  1  head entry valid.
- `m_data`  out  `FIFO_DATA_WIDTH`  head entry payload.
- `m_ready`  in  1  downstream accepts head.
- `count`  out  `$clog2(FIFO_DEPTH)+1`  current occupancy, 0..`FIFO_DEPTH`.
- `almost_full`  out  1  present only with `STREAM_FIFO_ALMOST_FULL_EN`.

## Operation
- Push when `s_valid && s_ready` at a rising edge; pop when `m_valid && m_ready`.
- Write/read pointers are `$clog2(FIFO_DEPTH)+1` bits. Low bits index storage and wrap naturally at `FIFO_DEPTH`. The MSB distinguishes full from empty.
- Empty: pointers equal. Full: low bits equal, MSBs differ.
- `count` is a registered counter: +1 on push-only, −1 on pop-only, unchanged on simultaneous push+pop or idle.
- `s_ready = !full`. It never depends on `m_ready`; there is no pass-through when full. A pop while full frees a slot for the following cycle.
- `m_valid = !empty`. There is no bypass when empty; a beat pushed into an empty FIFO is not visible in the same cycle.
- `m_data` is the storage entry at the read pointer. It is held stable while `m_valid && !m_ready`.
- Upstream must hold `s_data` stable while `s_valid && !s_ready`. The FIFO does not check this.
- Data order is strictly preserved. No beat is dropped or duplicated.

## Timing
- Reset values: `s_ready`=1, `m_valid`=0, `count`=0, `almost_full`=0. `m_data` is don't-care. Pointers are 0 and storage is not cleared.
- Reset mid-operation discards all contents at the next edge; the first post-reset cycle is empty.
- Write-to-read latency: a beat pushed at edge k drives `m_valid`=1 and `m_data` after edge k, for acceptance at edge k+1 earliest.
- Simultaneous push+pop with 0<count<DEPTH: both occur and `count` holds.
- At count=DEPTH with `m_ready`=1: pop only. `s_ready` rises after that edge.
- At count=0: push only. A pop is impossible because `m_valid`=0.
- Sustained throughput is 1 beat/cycle when neither side stalls.

## Configuration
- `STREAM_FIFO_ALMOST_FULL_EN` defined: the `almost_full` port exists. It is registered and equals (`count` ≥ `FIFO_AF_THRESH`), updated in the same cycle as `count`.
- Not defined: the port and its logic are absent, `FIFO_AF_THRESH` is ignored, and all other behaviour is identical.

## Structure
- `stream_fifo_pkg` holds:
  - default width/depth constants;
  - a function for pointer width (`$clog2(depth)+1`);
  - a `fifo_ptr_t`-style typedef for the default depth.
- Sub-module `stream_fifo_mem`: register-array storage with one write port (clocked) and one asynchronous read port. No reset on the array.
- Top level `stream_fifo` owns the pointers, `count`, flags and handshake.

## Test plan
- Reset then idle: after 3 reset cycles, `s_ready`=1, `m_valid`=0, `count`=0, held for 10 idle cycles.
- Fill without draining (`m_ready`=0), pushing 0x00000001..0x00000010 with DEPTH=16:
  - `count` reaches 16 and `s_ready`=0 after the 16th push;
  - a 17th beat 0xDEADBEEF is held off;
  - with the macro defined, `almost_full`=1 from `count`=12.
- Drain a full FIFO with `m_ready`=1: outputs 0x1..0x10 in order on consecutive cycles, then `m_valid`=0 and `count`=0.
- Streaming with `s_valid` and `m_ready` both held high, 64 incrementing beats:
  - 1 beat/cycle after the first-word latency;
  - `count` stays at 1;
  - the output sequence equals the input sequence.
- Wrap-around and random throttle: 1000 random 32-bit beats, matching the existing file-driven harness, with input throttle 2 and output throttle 3. The output must match the input file exactly, with no FAIL.
- Reset mid-burst with `count`=7: assert `reset` for 1 cycle. Afterwards `count`=0 and `m_valid`=0. Next beat 0xA5A5A5A5 is the first output seen.
